// File: rtl/change_dispenser.sv
// Change dispenser: queues vend/change requests and drives the item motor and coin
// ejectors one pulse at a time, each pulse followed by a timed hopper handshake.
module change_dispenser #(
    parameter int DEPTH        = 4,
    parameter int PULSE_CYCLES = 3,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   item,
    input  logic [3:0]             change,
    input  logic                   hopper_ack,
    output logic                   item_out,
    output logic                   coin10,
    output logic                   coin5,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] pending,
    output logic                   bad_change,
    output logic                   req_drop,
    output logic                   fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VEND, S_COIN10, S_COIN5, S_WAIT, S_FAULT
    } state_t;

    state_t        state;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    rounded;
    logic          capture;
    logic          full;
    logic          pop;
    logic          push;
    logic          vend;
    logic [3:0]    rem;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;

    // NOTE: assign a default before the if-chain so every path drives rounded and no latch is inferred.
    always_comb begin
        rounded = 4'd0;
        if (change >= 4'd15)
            rounded = 4'd15;
        else if (change >= 4'd10)
            rounded = 4'd10;
        else if (change >= 4'd5)
            rounded = 4'd5;
    end

    assign capture = item | (change != 4'd0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = (state == S_IDLE) && (count != '0);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push    = capture && (state != S_FAULT) && (!full || pop);
    assign busy    = (state != S_IDLE) || (count != '0);
    assign pending = count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bad_change <= 1'b0;
            req_drop   <= 1'b0;
        end else begin
            bad_change <= capture && (change != rounded);
            req_drop   <= capture && !push;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {item, rounded};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            vend     <= 1'b0;
            rem      <= 4'd0;
            pcnt     <= '0;
            tcnt     <= '0;
            item_out <= 1'b0;
            coin10   <= 1'b0;
            coin5    <= 1'b0;
            fault    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {vend, rem} <= mem[rd_ptr];
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    pcnt <= '0;
                    if (vend) begin
                        item_out <= 1'b1;
                        state    <= S_VEND;
                    end else if (rem >= 4'd10) begin
                        coin10 <= 1'b1;
                        state  <= S_COIN10;
                    end else if (rem >= 4'd5) begin
                        coin5 <= 1'b1;
                        state <= S_COIN5;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_VEND, S_COIN10, S_COIN5: begin
                    if (pcnt == PW'(PULSE_CYCLES - 1)) begin
                        item_out <= 1'b0;
                        coin10   <= 1'b0;
                        coin5    <= 1'b0;
                        tcnt     <= '0;
                        state    <= S_WAIT;
                        if (state == S_VEND)
                            vend <= 1'b0;
                        else if (state == S_COIN10)
                            rem <= rem - 4'd10;
                        else
                            rem <= rem - 4'd5;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                    end
                end
                S_WAIT: begin
                    if (hopper_ack) begin
                        state <= S_LOAD;
                    end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
                        fault <= 1'b1;
                        state <= S_FAULT;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_FAULT: state <= S_FAULT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected actuator pulses are queued when a
// request is driven and compared against pulses observed on the outputs.
module tb_change_dispenser;

    localparam int DEPTH = 4;
    localparam int PULSE = 3;
    localparam int TMO   = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       item;
    logic [3:0] change;
    logic       hopper_ack = 1'b0;
    logic       item_out, coin10, coin5, busy, bad_change, req_drop, fault;
    logic [2:0] pending;

    change_dispenser #(.DEPTH(DEPTH), .PULSE_CYCLES(PULSE), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .item(item), .change(change), .hopper_ack(hopper_ack),
        .item_out(item_out), .coin10(coin10), .coin5(coin5), .busy(busy),
        .pending(pending), .bad_change(bad_change), .req_drop(req_drop), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 item motor, 1 coin10, 2 coin5
        int width;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  ack_delay = 0, ack_cd = 0;
    int  r_item = 0, r_c10 = 0, r_c5 = 0;
    int  overlap = 0, bad_cnt = 0, drop_cnt = 0;

    // Monitor and hopper model: records finished pulses and answers each after ack_delay cycles.
    always @(negedge clk) begin
        hopper_ack = 1'b0;
        if (reset) begin
            r_item = 0; r_c10 = 0; r_c5 = 0; ack_cd = 0;
        end else begin
            if (ack_cd > 0) begin
                ack_cd--;
                if (ack_cd == 0) hopper_ack = 1'b1;
            end
            if (int'(item_out) + int'(coin10) + int'(coin5) > 1) overlap++;
            if (bad_change) bad_cnt++;
            if (req_drop) drop_cnt++;
            if (item_out) r_item++;
            else if (r_item > 0) begin
                obs_q.push_back('{kind: 0, width: r_item}); r_item = 0; ack_cd = ack_delay;
            end
            if (coin10) r_c10++;
            else if (r_c10 > 0) begin
                obs_q.push_back('{kind: 1, width: r_c10}); r_c10 = 0; ack_cd = ack_delay;
            end
            if (coin5) r_c5++;
            else if (r_c5 > 0) begin
                obs_q.push_back('{kind: 2, width: r_c5}); r_c5 = 0; ack_cd = ack_delay;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Reference model of the dispensing order for one request.
    task automatic expect_txn(input logic it, input int ch);
        int r;
        if (it) exp_q.push_back('{kind: 0, width: PULSE});
        r = ch - (ch % 5);
        if (r >= 10) begin
            exp_q.push_back('{kind: 1, width: PULSE});
            r -= 10;
        end
        if (r >= 5) exp_q.push_back('{kind: 2, width: PULSE});
    endtask

    task automatic drive_req(input logic it, input logic [3:0] ch, input bit track);
        item = it;
        change = ch;
        if (track) expect_txn(it, int'(ch));
        cyc(1);
        item = 1'b0;
        change = 4'd0;
    endtask

    task automatic test_reset;
        cyc(2);
        n_checks++;
        if ({item_out, coin10, coin5, busy, bad_change, req_drop, fault} !== 7'b0)
            $display("FAIL reset_outputs got %b want 0000000",
                     {item_out, coin10, coin5, busy, bad_change, req_drop, fault});
        n_checks++;
        if (pending !== 3'd0) $display("FAIL reset_pending got %0d want 0", pending);
        reset = 1'b0;
        cyc(1);
    endtask

    task automatic test_vend_change5;
        int b0;
        ev_t e, o;
        b0 = bad_cnt;
        ack_delay = 2;
        drive_req(1'b1, 4'd5, 1'b1);
        n_checks++;
        if (pending !== 3'd1) begin n_fail++; $display("FAIL v5_pending_after_capture got %0d want 1", pending); end
        cyc(1);
        n_checks++;
        if (item_out !== 1'b0) begin n_fail++; $display("FAIL v5_load_cycle item_out got %b want 0", item_out); end
        cyc(1);
        n_checks++;
        if (item_out !== 1'b1) begin n_fail++; $display("FAIL v5_first_pulse item_out got %b want 1", item_out); end
        for (int i = 0; i < 100 && busy; i++) cyc(1);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL v5_idle busy got %b want 0", busy); end
        n_checks++;
        if (pending !== 3'd0) begin n_fail++; $display("FAIL v5_pending_end got %0d want 0", pending); end
        n_checks++;
        if (bad_cnt !== b0) begin n_fail++; $display("FAIL v5_bad_change got %0d want %0d", bad_cnt, b0); end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL v5_pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.width !== e.width) begin
                n_fail++; $display("FAIL v5_pulse got kind %0d width %0d want kind %0d width %0d", o.kind, o.width, e.kind, e.width);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_refund15;
        int b0, ov0;
        ev_t e, o;
        b0 = bad_cnt; ov0 = overlap;
        ack_delay = 1;
        drive_req(1'b0, 4'd15, 1'b1);
        for (int i = 0; i < 100 && busy; i++) cyc(1);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL r15_idle busy got %b want 0", busy); end
        n_checks++;
        if (bad_cnt !== b0) begin n_fail++; $display("FAIL r15_bad_change got %0d want %0d", bad_cnt, b0); end
        n_checks++;
        if (overlap !== ov0) begin n_fail++; $display("FAIL r15_overlap got %0d want %0d", overlap, ov0); end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL r15_pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.width !== e.width) begin
                n_fail++; $display("FAIL r15_pulse got kind %0d width %0d want kind %0d width %0d", o.kind, o.width, e.kind, e.width);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bad_change7;
        int b0;
        ev_t e, o;
        b0 = bad_cnt;
        ack_delay = 1;
        drive_req(1'b1, 4'd7, 1'b1);
        n_checks++;
        if (bad_change !== 1'b1) begin n_fail++; $display("FAIL b7_pulse_high got %b want 1", bad_change); end
        cyc(1);
        n_checks++;
        if (bad_change !== 1'b0) begin n_fail++; $display("FAIL b7_pulse_low got %b want 0", bad_change); end
        for (int i = 0; i < 100 && busy; i++) cyc(1);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b7_idle busy got %b want 0", busy); end
        n_checks++;
        if (bad_cnt !== b0 + 1) begin n_fail++; $display("FAIL b7_bad_count got %0d want %0d", bad_cnt, b0 + 1); end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL b7_pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.width !== e.width) begin
                n_fail++; $display("FAIL b7_pulse got kind %0d width %0d want kind %0d width %0d", o.kind, o.width, e.kind, e.width);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        int d0;
        ev_t e, o;
        d0 = drop_cnt;
        ack_delay = 0;
        for (int i = 0; i < 6; i++) begin
            item = 1'b0;
            change = 4'd10;
            if (i == 0) expect_txn(1'b0, 10);
            cyc(1);
        end
        change = 4'd0;
        n_checks++;
        if (req_drop !== 1'b1) begin n_fail++; $display("FAIL b2b_req_drop got %b want 1", req_drop); end
        n_checks++;
        if (pending !== 3'd4) begin n_fail++; $display("FAIL b2b_pending got %0d want 4", pending); end
        n_checks++;
        if (drop_cnt !== d0 + 1) begin n_fail++; $display("FAIL b2b_drop_count got %0d want %0d", drop_cnt, d0 + 1); end
        cyc(14);
        n_checks++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL b2b_fault_early got %b want 0", fault); end
        cyc(1);
        n_checks++;
        if (fault !== 1'b1) begin n_fail++; $display("FAIL b2b_fault_timeout got %b want 1", fault); end
        n_checks++;
        if ({item_out, coin10, coin5} !== 3'b000) begin
            n_fail++; $display("FAIL b2b_fault_actuators got %b want 000", {item_out, coin10, coin5});
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL b2b_pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.width !== e.width) begin
                n_fail++; $display("FAIL b2b_pulse got kind %0d width %0d want kind %0d width %0d", o.kind, o.width, e.kind, e.width);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_fault_drop;
        ev_t e, o;
        drive_req(1'b1, 4'd0, 1'b0);
        n_checks++;
        if (req_drop !== 1'b1) begin n_fail++; $display("FAIL fd_req_drop got %b want 1", req_drop); end
        n_checks++;
        if (pending !== 3'd4) begin n_fail++; $display("FAIL fd_pending_frozen got %0d want 4", pending); end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({item_out, coin10, coin5, busy, bad_change, req_drop, fault} !== 7'b0) begin
            n_fail++; $display("FAIL fd_reset_outputs got %b want 0000000",
                               {item_out, coin10, coin5, busy, bad_change, req_drop, fault});
        end
        n_checks++;
        if (pending !== 3'd0) begin n_fail++; $display("FAIL fd_reset_pending got %0d want 0", pending); end
        cyc(1);
        reset = 1'b0;
        cyc(1);
        obs_q.delete(); exp_q.delete();
        ack_delay = 1;
        drive_req(1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 100 && busy; i++) cyc(1);
        n_checks++;
        if (busy !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL fd_recover busy/fault got %b%b want 00", busy, fault);
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL fd_pulse_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o.kind !== e.kind || o.width !== e.width) begin
                n_fail++; $display("FAIL fd_pulse got kind %0d width %0d want kind %0d width %0d", o.kind, o.width, e.kind, e.width);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_pulse;
        ack_delay = 1;
        drive_req(1'b0, 4'd10, 1'b0);
        cyc(2);
        n_checks++;
        if (coin10 !== 1'b1) begin n_fail++; $display("FAIL rm_coin10_first got %b want 1", coin10); end
        cyc(1);
        n_checks++;
        if (coin10 !== 1'b1) begin n_fail++; $display("FAIL rm_coin10_second got %b want 1", coin10); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (coin10 !== 1'b0) begin n_fail++; $display("FAIL rm_coin10_async got %b want 0", coin10); end
        cyc(1);
        reset = 1'b0;
        cyc(10);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %b want 0", busy); end
        n_checks++;
        if (obs_q.size() !== 0) begin n_fail++; $display("FAIL rm_no_actuation got %0d pulses want 0", obs_q.size()); end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        item = 1'b0;
        change = 4'd0;
        test_reset();
        test_vend_change5();
        test_refund15();
        test_bad_change7();
        test_back_to_back();
        test_fault_drop();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
